output_port_credit_ctrl: RTL and testbench

Router output stage directly downstream of the crossbar. It registers each port's switched flit and write strobe toward the neighbouring router or endpoint. Per output port and VC, it keeps a credit counter mirroring the downstream buffer occupancy and an idle/busy packet-ownership state. Per-VC credit-available and VC-idle vectors are returned to the allocators that drive the crossbar grants.

---
 rtl/noc_out_pkg.sv | 25 ++
 rtl/output_port_credit_ctrl_if.sv | 41 ++++
 rtl/out_vc_credit_cnt.sv | 87 ++++++++
 rtl/output_port_credit_ctrl.sv | 91 +++++++++
 tb/tb_output_port_credit_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/noc_out_pkg.sv
// Shared definitions for the router output credit stage.
// Flit field offsets, credit width helper and VC state encoding.
package noc_out_pkg;

  localparam int V_DEF    = 4;
  localparam int P_DEF    = 5;
  localparam int FPAY_DEF = 32;
  localparam int B_DEF    = 4;
  localparam int FW_DEF   = 2 + V_DEF + FPAY_DEF;

  // Offsets for the default geometry; other widths shift them.
  localparam int HDR_BIT  = FW_DEF - 1;
  localparam int TAIL_BIT = FW_DEF - 2;
  localparam int VC_LSB   = FPAY_DEF;

  function automatic int credit_w(input int b);
    return $clog2(b + 1);
  endfunction

  typedef enum logic {
    VC_IDLE = 1'b0,
    VC_BUSY = 1'b1
  } vc_state_e;

endpackage

// File: rtl/output_port_credit_ctrl_if.sv
// Crossbar-side and link-side bundle of the output credit stage.
// master drives flits and credits, slave is the credit stage.
interface output_port_credit_ctrl_if #(
  parameter int P    = 5,
  parameter int V    = 4,
  parameter int Fpay = 32
);
  localparam int FW = 2 + V + Fpay;

  logic [P*FW-1:0] flit_in_all;
  logic [P-1:0]    flit_in_we_all;
  logic [P*V-1:0]  credit_in_all;
  logic [P*FW-1:0] flit_out_all;
  logic [P-1:0]    flit_out_wr_all;
  logic [P*V-1:0]  credit_avail_all;
  logic [P*V-1:0]  vc_idle_all;
  logic [P-1:0]    credit_err_all;

  modport master (
    output flit_in_all,
    output flit_in_we_all,
    output credit_in_all,
    input  flit_out_all,
    input  flit_out_wr_all,
    input  credit_avail_all,
    input  vc_idle_all,
    input  credit_err_all
  );

  modport slave (
    input  flit_in_all,
    input  flit_in_we_all,
    input  credit_in_all,
    output flit_out_all,
    output flit_out_wr_all,
    output credit_avail_all,
    output vc_idle_all,
    output credit_err_all
  );

endinterface

// File: rtl/out_vc_credit_cnt.sv
// One VC: saturating credit counter plus idle/busy ownership.
// Error detection present only with OUT_CREDIT_ERR_EN defined.
module out_vc_credit_cnt
  import noc_out_pkg::*;
#(
  parameter int B = B_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic hdr,
  input  logic tail,
  input  logic inc,
  output logic avail,
  output logic idle,
  output logic err
);

  localparam int CW = credit_w(B);
  localparam logic [CW-1:0] BMAX = CW'(B);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  vc_state_e     st;
  vc_state_e     st_nx;

  // Counter and ownership state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= BMAX;
      st  <= VC_IDLE;
    end else begin
      cnt <= cnt_nx;
      st  <= st_nx;
    end
  end

  // Saturating credit update; a write and a credit cancel out.
  always_comb begin
    cnt_nx = cnt;
    unique case (1'b1)
      (we && !inc): if (cnt != '0) cnt_nx = cnt - CW'(1);
      (inc && !we): if (cnt != BMAX) cnt_nx = cnt + CW'(1);
      default: cnt_nx = cnt;
    endcase
  end

  // Header opens a packet unless it is also the tail.
  always_comb begin
    st_nx = st;
    if (we) begin
      if (hdr) begin
        if (st == VC_IDLE && !tail) st_nx = VC_BUSY;
      end else if (tail) begin
        st_nx = VC_IDLE;
      end
    end
  end

  assign avail = (cnt != '0);
  assign idle  = (st == VC_IDLE);

`ifdef OUT_CREDIT_ERR_EN
  logic err_q;
  logic err_ev;

  // Underflow, overflow, or a broken header/tail sequence.
  always_comb begin
    err_ev = 1'b0;
    if (we && !inc && cnt == '0) err_ev = 1'b1;
    if (inc && !we && cnt == BMAX) err_ev = 1'b1;
    if (we && hdr && st == VC_BUSY) err_ev = 1'b1;
    if (we && !hdr && st == VC_IDLE) err_ev = 1'b1;
  end

  // Sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (err_ev) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/output_port_credit_ctrl.sv
// Router output stage: flit register, per-VC credits and ownership.
// Optional error detection with OUT_CREDIT_ERR_EN defined.
module output_port_credit_ctrl
  import noc_out_pkg::*;
#(
  parameter int V    = V_DEF,
  parameter int P    = P_DEF,
  parameter int Fpay = FPAY_DEF,
  parameter int B    = B_DEF
) (
  input logic clk,
  input logic reset,
  output_port_credit_ctrl_if.slave bus
);

  localparam int FW  = 2 + V + Fpay;
  localparam int DF  = Fpay - FPAY_DEF;
  localparam int DV  = V - V_DEF;
  localparam int HDR = HDR_BIT + DF + DV;
  localparam int TL  = TAIL_BIT + DF + DV;
  localparam int VCL = VC_LSB + DF;

  logic [P*FW-1:0] flit_q;
  logic [P-1:0]    wr_q;
  logic [P*V-1:0]  avail_v;
  logic [P*V-1:0]  idle_v;
  logic [P*V-1:0]  vc_err;
  logic [P-1:0]    vc_ok;
  logic [P-1:0]    port_err;

  // Link register; data is captured every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_q <= '0;
      wr_q   <= '0;
    end else begin
      flit_q <= bus.flit_in_all;
      wr_q   <= bus.flit_in_we_all;
    end
  end

  for (genvar p = 0; p < P; p++) begin : g_port
    logic [V-1:0] vc;
    logic         hdr;
    logic         tail;
    logic         we;

    assign vc       = bus.flit_in_all[p*FW+VCL +: V];
    assign hdr      = bus.flit_in_all[p*FW+HDR];
    assign tail     = bus.flit_in_all[p*FW+TL];
    assign we       = bus.flit_in_we_all[p];
    assign vc_ok[p] = $onehot(vc);

    for (genvar v = 0; v < V; v++) begin : g_vc
      out_vc_credit_cnt #(
        .B(B)
      ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .we   (we && vc_ok[p] && vc[v]),
        .hdr  (hdr),
        .tail (tail),
        .inc  (bus.credit_in_all[p*V+v]),
        .avail(avail_v[p*V+v]),
        .idle (idle_v[p*V+v]),
        .err  (vc_err[p*V+v])
      );
    end

`ifdef OUT_CREDIT_ERR_EN
    logic bad_q;

    // Sticky flag for writes with a zero or multi-hot VC field.
    always_ff @(posedge clk) begin
      if (reset) bad_q <= 1'b0;
      else if (we && !vc_ok[p]) bad_q <= 1'b1;
    end

    assign port_err[p] = bad_q | (|vc_err[p*V +: V]);
`else
    assign port_err[p] = |vc_err[p*V +: V];
`endif
  end

  assign bus.flit_out_all     = flit_q;
  assign bus.flit_out_wr_all  = wr_q;
  assign bus.credit_avail_all = avail_v;
  assign bus.vc_idle_all      = idle_v;
  assign bus.credit_err_all   = port_err;

endmodule

// File: tb/tb_output_port_credit_ctrl.sv
// Directed scoreboard bench for output_port_credit_ctrl.
// Error expectations follow OUT_CREDIT_ERR_EN.
module tb_output_port_credit_ctrl;

  localparam int P    = 5;
  localparam int V    = 4;
  localparam int FPAY = 32;
  localparam int B    = 4;
  localparam int FW   = 2 + V + FPAY;

`ifdef OUT_CREDIT_ERR_EN
  localparam logic EE = 1'b1;
`else
  localparam logic EE = 1'b0;
`endif

  typedef struct {
    int              id;
    logic [P*FW-1:0] flit;
    logic [P-1:0]    wr;
    logic [P*V-1:0]  avail;
    logic [P*V-1:0]  idle;
    logic [P-1:0]    err;
  } exp_t;

  logic clk;
  logic reset;

  output_port_credit_ctrl_if #(.P(P), .V(V), .Fpay(FPAY)) bus ();

  output_port_credit_ctrl #(
    .V(V), .P(P), .Fpay(FPAY), .B(B)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int step_id = 0;

  logic [P*FW-1:0] fin;
  logic [P-1:0]    fwe;
  logic [P*V-1:0]  fcr;
  logic            rst;
  logic [P*V-1:0]  exp_avail;
  logic [P*V-1:0]  exp_idle;
  logic [P-1:0]    exp_err;

  function automatic logic [FW-1:0] mk(
    input logic h, input logic t,
    input logic [V-1:0] vc, input logic [FPAY-1:0] pl);
    return {h, t, vc, pl};
  endfunction

  task automatic put(input int p, input logic [FW-1:0] f);
    fin[p*FW +: FW] = f;
    fwe[p] = 1'b1;
  endtask

  task automatic step();
    exp_t e;
    bus.flit_in_all    = fin;
    bus.flit_in_we_all = fwe;
    bus.credit_in_all  = fcr;
    reset = rst;
    @(posedge clk);
    e.id    = step_id;
    e.flit  = rst ? '0 : fin;
    e.wr    = rst ? '0 : fwe;
    e.avail = exp_avail;
    e.idle  = exp_idle;
    e.err   = exp_err;
    q.push_back(e);
    step_id++;
    #1;
    fin = '0;
    fwe = '0;
    fcr = '0;
  endtask

  task automatic chk(input string nm, input int id,
                     input logic [P*FW-1:0] got,
                     input logic [P*FW-1:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL step%0d %s got %h want %h", id, nm, got, want);
    end
  endtask

  // Monitor: compare each registered output against its expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("flit_out", e.id, bus.flit_out_all, e.flit);
        chk("flit_wr", e.id, P*FW'(bus.flit_out_wr_all), P*FW'(e.wr));
        chk("avail", e.id, P*FW'(bus.credit_avail_all), P*FW'(e.avail));
        chk("idle", e.id, P*FW'(bus.vc_idle_all), P*FW'(e.idle));
        chk("err", e.id, P*FW'(bus.credit_err_all), P*FW'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    fin = '0; fwe = '0; fcr = '0; rst = 1'b1;
    reset = 1'b1;
    bus.flit_in_all    = '0;
    bus.flit_in_we_all = '0;
    bus.credit_in_all  = '0;
    exp_avail = '1;
    exp_idle  = '1;
    exp_err   = '0;

    // Reset values
    step();
    rst = 1'b0;
    // Data captured even with we=0
    fin[1*FW +: FW] = mk(1'b1, 1'b0, 4'b0100, 32'hDEADBEEF);
    step();
    // Port 2 single-flit packet on VC1: stays idle, cnt 3
    put(2, mk(1'b1, 1'b1, 4'b0010, 32'h2222_0001));
    step();

    // Port 0 VC3: header, body, body, tail
    put(0, mk(1'b1, 1'b0, 4'b1000, 32'hA0));
    exp_idle[3] = 1'b0;
    step();
    put(0, mk(1'b0, 1'b0, 4'b1000, 32'hA1));
    step();
    put(0, mk(1'b0, 1'b0, 4'b1000, 32'hA2));
    step();
    put(0, mk(1'b0, 1'b1, 4'b1000, 32'hA3));
    exp_idle[3]  = 1'b1;
    exp_avail[3] = 1'b0;
    step();
    // Credit returns one slot
    fcr[3] = 1'b1;
    exp_avail[3] = 1'b1;
    step();

    // Port 1 VC0 drained by four single-flit packets
    for (int i = 0; i < 4; i++) begin
      put(1, mk(1'b1, 1'b1, 4'b0001, 32'hB0 + i));
      if (i == 3) exp_avail[4] = 1'b0;
      step();
    end
    // Write and credit together at cnt 0: no change, no error
    put(1, mk(1'b1, 1'b1, 4'b0001, 32'hB8));
    fcr[4] = 1'b1;
    step();
    // Write alone at cnt 0: underflow
    put(1, mk(1'b1, 1'b1, 4'b0001, 32'hB9));
    exp_err[1] = EE;
    step();
    // Error is sticky
    step();

    // Credit at cnt=B on port 4 VC2: overflow
    fcr[4*V+2] = 1'b1;
    exp_err[4] = EE;
    step();

    // Multi-hot VC field: forwarded, no state change
    put(3, mk(1'b1, 1'b0, 4'b0110, 32'hC3));
    exp_err[3] = EE;
    step();
    // Zero VC field: forwarded, no state change
    put(3, mk(1'b1, 1'b0, 4'b0000, 32'hC4));
    step();

    // Port 0 VC0: two singles then open a packet (cnt 1, busy)
    put(0, mk(1'b1, 1'b1, 4'b0001, 32'hD0));
    step();
    put(0, mk(1'b1, 1'b1, 4'b0001, 32'hD1));
    step();
    put(0, mk(1'b1, 1'b0, 4'b0001, 32'hD2));
    exp_idle[0] = 1'b0;
    step();
    // Reset mid-packet with a flit being written
    rst = 1'b1;
    put(0, mk(1'b0, 1'b0, 4'b0001, 32'hD3));
    exp_avail = '1;
    exp_idle  = '1;
    exp_err   = '0;
    step();
    rst = 1'b0;
    // Counter back at B: exactly four writes to empty
    for (int i = 0; i < 4; i++) begin
      put(0, mk(1'b1, 1'b1, 4'b0001, 32'hE0 + i));
      if (i == 3) exp_avail[0] = 1'b0;
      step();
    end

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
